// File: rtl/cache_nway_pkg.sv
// ---------------------------------------------------------------------------
// cache_nway_pkg
// Shared definitions for the N-way cache controller slice.
//   ctrlState_t  : controller FSM states
//   PLRU_*       : tree-PLRU bit ordering (heap order, root at bit 0;
//                  a bit value of 0 points left, 1 points right; the way
//                  index LSB selects the branch at the root level)
//   plruChild()  : heap index of a node's child in a given direction
// ---------------------------------------------------------------------------
package cache_nway_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    REFILL    = 3'd2,
    WAIT_MEM  = 3'd3,
    WRITE     = 3'd4,
    GIVE      = 3'd5,
    FLUSH     = 3'd6
  } ctrlState_t;

  localparam int   PLRU_ROOT  = 0;
  localparam logic PLRU_LEFT  = 1'b0;
  localparam logic PLRU_RIGHT = 1'b1;

  function automatic int plruChild(input int node, input logic dir);
    return 2 * node + 1 + int'(dir);
  endfunction

endpackage

// File: rtl/cache_nway_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_nway_ctrl_if
// Bundles every controller-facing signal except clk/reset.
//   master : controller side (drives handshake readies, array write
//            enables, memory requests, flush status)
//   slave  : environment side (processor, tag/dirty/PLRU arrays, memory)
// Groups: processor request/response, array control, memory port, flush.
// ---------------------------------------------------------------------------
interface cache_nway_ctrl_if #(
  parameter int NWAYS = 4,
  parameter int NSETS = 16
);

  localparam int WW  = $clog2(NWAYS);
  localparam int FIW = $clog2(NSETS * NWAYS);

  logic             memreq_val;
  logic             memreq_rdy;
  logic             memreq_type;
  logic             memresp_val;
  logic             memresp_rdy;

  logic [NWAYS-1:0] way_hit;
  logic             victim_dirty;
  logic [NWAYS-2:0] plru_rd;

  logic [WW-1:0]    sel_way;
  logic             plru_wen;
  logic [NWAYS-2:0] plru_wd;
  logic [NWAYS-1:0] tarray_wen;
  logic [NWAYS-1:0] valid_wen;
  logic             darray_wen;
  logic             darray_refill_sel;
  logic             dirty_wen;
  logic             dirty_wd;

  logic             mreq_val;
  logic             mreq_rdy;
  logic             mreq_rw;
  logic             mresp_val;
  logic             mresp_rdy;

  logic             flush;
  logic             flush_done;
  logic [FIW-1:0]   flush_idx;
  logic             flush_active;

  modport master (
    input  memreq_val, memreq_type, memresp_rdy,
    input  way_hit, victim_dirty, plru_rd,
    input  mreq_rdy, mresp_val, flush,
    output memreq_rdy, memresp_val,
    output sel_way, plru_wen, plru_wd, tarray_wen, valid_wen,
    output darray_wen, darray_refill_sel, dirty_wen, dirty_wd,
    output mreq_val, mreq_rw, mresp_rdy,
    output flush_done, flush_idx, flush_active
  );

  modport slave (
    output memreq_val, memreq_type, memresp_rdy,
    output way_hit, victim_dirty, plru_rd,
    output mreq_rdy, mresp_val, flush,
    input  memreq_rdy, memresp_val,
    input  sel_way, plru_wen, plru_wd, tarray_wen, valid_wen,
    input  darray_wen, darray_refill_sel, dirty_wen, dirty_wd,
    input  mreq_val, mreq_rw, mresp_rdy,
    input  flush_done, flush_idx, flush_active
  );

endinterface

// File: rtl/cache_nway_plru.sv
// ---------------------------------------------------------------------------
// cache_nway_plru
// Combinational tree-PLRU for one set.
//   i_plruRd  : tree bits of the addressed set
//   i_usedWay : way just used (hit or refill)
//   o_victim  : way reached by walking i_plruRd from the root
//   o_plruWd  : i_plruRd with every bit on i_usedWay's path pointing away
// ---------------------------------------------------------------------------
module cache_nway_plru
  import cache_nway_pkg::*;
#(
  parameter int NWAYS = 4
) (
  input  logic [NWAYS-2:0]         i_plruRd,
  input  logic [$clog2(NWAYS)-1:0] i_usedWay,
  output logic [$clog2(NWAYS)-1:0] o_victim,
  output logic [NWAYS-2:0]         o_plruWd
);

  localparam int LVLS = $clog2(NWAYS);

  // Victim walk: at each level follow the stored direction; the chosen
  // direction at level l becomes bit l of the victim way.
  always_comb begin
    int   node;
    logic dir;
    o_victim = '0;
    node     = PLRU_ROOT;
    dir      = PLRU_LEFT;
    for (int l = 0; l < LVLS; l++) begin
      for (int b = 0; b < NWAYS - 1; b++) begin
        if (b == node) dir = i_plruRd[b];
      end
      o_victim[l] = dir;
      node        = plruChild(node, dir);
    end
  end

  // Update: flip each node on the used way's path to the opposite side,
  // leaving the off-path nodes as they were read.
  always_comb begin
    int   node;
    logic usedBit;
    o_plruWd = i_plruRd;
    node     = PLRU_ROOT;
    usedBit  = PLRU_LEFT;
    for (int l = 0; l < LVLS; l++) begin
      usedBit = i_usedWay[l];
      for (int b = 0; b < NWAYS - 1; b++) begin
        if (b == node) o_plruWd[b] = (usedBit == PLRU_LEFT) ? PLRU_RIGHT : PLRU_LEFT;
      end
      node = plruChild(node, usedBit);
    end
  end

endmodule

// File: rtl/cache_nway_ctrl.sv
// ---------------------------------------------------------------------------
// cache_nway_ctrl
// Control FSM of a write-back, write-allocate N-way cache with tree-PLRU
// replacement and an optional full-cache flush walker.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : cache_nway_ctrl_if.master (processor handshake, array
//                control, memory port, flush status)
// Build option: define CACHE_NWAY_CTRL_FLUSH_EN to include the FLUSH state
// and its entry counter; otherwise flush is ignored and the flush status
// outputs stay 0.
// ---------------------------------------------------------------------------
module cache_nway_ctrl
  import cache_nway_pkg::*;
#(
  parameter int NWAYS = 4,
  parameter int NSETS = 16
) (
  input  logic             clk,
  input  logic             reset,
  cache_nway_ctrl_if.master bus
);

  localparam int WW  = $clog2(NWAYS);
  localparam int FIW = $clog2(NSETS * NWAYS);

  ctrlState_t       r_state, w_next;
  logic             r_pendWrite, w_pendNext;
  logic [WW-1:0]    r_way, w_wayNext;
  logic [WW-1:0]    w_hitWay, w_victim, w_usedWay;
  logic [NWAYS-2:0] w_plruWd;
  logic [NWAYS-1:0] w_wayOneHot;
  logic             w_flushReq;

`ifdef CACHE_NWAY_CTRL_FLUSH_EN
  localparam logic [FIW-1:0] LAST_IDX = FIW'(NSETS * NWAYS - 1);
  logic [FIW-1:0] r_flushIdx, w_idxNext;
  assign w_flushReq = bus.flush;
`else
  assign w_flushReq = 1'b0;
`endif

  // Binary encode of the one-hot tag match.
  always_comb begin
    w_hitWay = '0;
    for (int i = 0; i < NWAYS; i++) begin
      if (bus.way_hit[i]) w_hitWay = WW'(i);
    end
  end

  // During refill the way being filled is the remembered victim; otherwise
  // the PLRU update is for the way that just hit.
  assign w_usedWay   = (r_state == WAIT_MEM) ? r_way : w_hitWay;
  assign w_wayOneHot = {{(NWAYS-1){1'b0}}, 1'b1} << r_way;

  cache_nway_plru #(.NWAYS(NWAYS)) u_plru (
    .i_plruRd  (bus.plru_rd),
    .i_usedWay (w_usedWay),
    .o_victim  (w_victim),
    .o_plruWd  (w_plruWd)
  );

  // State, pending-write flag and remembered way.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pendWrite <= 1'b0;
      r_way       <= '0;
    end else begin
      r_state     <= w_next;
      r_pendWrite <= w_pendNext;
      r_way       <= w_wayNext;
    end
  end

`ifdef CACHE_NWAY_CTRL_FLUSH_EN
  // Flush entry counter: {way, set}; parked at 0 outside FLUSH.
  always_ff @(posedge clk) begin
    if (reset) r_flushIdx <= '0;
    else       r_flushIdx <= w_idxNext;
  end
`endif

  // Next-state and outputs. Everything is held at 0 while reset is high so
  // an interrupted refill or flush issues nothing more to memory.
  always_comb begin
    w_next                = r_state;
    w_pendNext            = r_pendWrite;
    w_wayNext             = r_way;
`ifdef CACHE_NWAY_CTRL_FLUSH_EN
    w_idxNext             = r_flushIdx;
`endif
    bus.memreq_rdy        = 1'b0;
    bus.memresp_val       = 1'b0;
    bus.sel_way           = '0;
    bus.plru_wen          = 1'b0;
    bus.plru_wd           = '0;
    bus.tarray_wen        = '0;
    bus.valid_wen         = '0;
    bus.darray_wen        = 1'b0;
    bus.darray_refill_sel = 1'b0;
    bus.dirty_wen         = 1'b0;
    bus.dirty_wd          = 1'b0;
    bus.mreq_val          = 1'b0;
    bus.mreq_rw           = 1'b0;
    bus.mresp_rdy         = 1'b0;
    bus.flush_done        = 1'b0;
    bus.flush_idx         = '0;
    bus.flush_active      = 1'b0;

    if (!reset) begin
`ifdef CACHE_NWAY_CTRL_FLUSH_EN
      bus.flush_idx = r_flushIdx;
`endif
      case (r_state)
        IDLE: begin
          if (w_flushReq) begin
            w_next = FLUSH;
          end else begin
            bus.memreq_rdy = 1'b1;
            if (bus.memreq_val) begin
              if (|bus.way_hit) begin
                bus.memresp_val = 1'b1;
                bus.sel_way     = w_hitWay;
                bus.plru_wen    = 1'b1;
                bus.plru_wd     = w_plruWd;
                w_wayNext       = w_hitWay;
                if (bus.memreq_type) begin
                  bus.darray_wen = 1'b1;
                  bus.dirty_wen  = 1'b1;
                  bus.dirty_wd   = 1'b1;
                end
                if (!bus.memresp_rdy) w_next = GIVE;
              end else begin
                // Present the victim so the datapath can look up its dirty bit.
                bus.sel_way = w_victim;
                w_wayNext   = w_victim;
                w_pendNext  = bus.memreq_type;
                w_next      = bus.victim_dirty ? WRITEBACK : REFILL;
              end
            end
          end
        end

        WRITEBACK: begin
          bus.mreq_val  = 1'b1;
          bus.mreq_rw   = 1'b1;
          bus.sel_way   = r_way;
          bus.dirty_wen = 1'b1;
          bus.dirty_wd  = 1'b0;
          if (bus.mreq_rdy) w_next = REFILL;
        end

        REFILL: begin
          bus.mreq_val = 1'b1;
          bus.sel_way  = r_way;
          if (bus.mreq_rdy) w_next = WAIT_MEM;
        end

        WAIT_MEM: begin
          bus.mresp_rdy = 1'b1;
          bus.sel_way   = r_way;
          if (bus.mresp_val) begin
            bus.darray_wen        = 1'b1;
            bus.darray_refill_sel = 1'b1;
            bus.tarray_wen        = w_wayOneHot;
            bus.valid_wen         = w_wayOneHot;
            bus.plru_wen          = 1'b1;
            bus.plru_wd           = w_plruWd;
            w_next                = WRITE;
          end
        end

        // Merge the processor's store into the freshly filled line.
        WRITE: begin
          bus.sel_way = r_way;
          if (r_pendWrite) begin
            bus.darray_wen = 1'b1;
            bus.dirty_wen  = 1'b1;
            bus.dirty_wd   = 1'b1;
            w_pendNext     = 1'b0;
          end
          w_next = GIVE;
        end

        GIVE: begin
          bus.memresp_val = 1'b1;
          bus.sel_way     = r_way;
          if (bus.memresp_rdy) w_next = IDLE;
        end

        FLUSH: begin
`ifdef CACHE_NWAY_CTRL_FLUSH_EN
          bus.flush_active = 1'b1;
          bus.sel_way      = r_flushIdx[FIW-1 -: WW];
          if (bus.victim_dirty) begin
            bus.mreq_val  = 1'b1;
            bus.mreq_rw   = 1'b1;
            bus.dirty_wen = bus.mreq_rdy;
          end
          // Clean entries retire immediately; dirty ones once memory accepts.
          if (!bus.victim_dirty || bus.mreq_rdy) begin
            if (r_flushIdx == LAST_IDX) begin
              bus.flush_done = 1'b1;
              w_idxNext      = '0;
              w_next         = IDLE;
            end else begin
              w_idxNext = r_flushIdx + FIW'(1);
            end
          end
`else
          w_next = IDLE;
`endif
        end

        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_nway_ctrl
// Directed bench for cache_nway_ctrl (NWAYS=4, NSETS=16). Each scenario task
// drives the interface and compares against hand-computed values. The flush
// scenario follows CACHE_NWAY_CTRL_FLUSH_EN.
// ---------------------------------------------------------------------------
module tb_cache_nway_ctrl;
  import cache_nway_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cache_nway_ctrl_if #(.NWAYS(4), .NSETS(16)) bus ();

  cache_nway_ctrl #(.NWAYS(4), .NSETS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.memreq_val   = 1'b0;
    bus.memreq_type  = 1'b0;
    bus.memresp_rdy  = 1'b0;
    bus.way_hit      = '0;
    bus.victim_dirty = 1'b0;
    bus.plru_rd      = '0;
    bus.mreq_rdy     = 1'b0;
    bus.mresp_val    = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.memreq_val = 1'b1;
    bus.way_hit    = 4'b0001;
    step();
    #1;
    checks++;
    if ({bus.memreq_rdy, bus.memresp_val, bus.plru_wen, bus.mreq_val} !== 4'b0000) begin
      $display("[TB] FAIL reset_outputs: got %b want 0000",
               {bus.memreq_rdy, bus.memresp_val, bus.plru_wen, bus.mreq_val});
      errors++;
    end
    clearInputs();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.memreq_rdy, bus.memresp_val, bus.flush_idx} !== {1'b1, 1'b0, 6'd0}) begin
      $display("[TB] FAIL reset_idle: got %b want 10000000",
               {bus.memreq_rdy, bus.memresp_val, bus.flush_idx});
      errors++;
    end
  endtask

  task automatic test_read_hit();
    bus.memreq_val  = 1'b1;
    bus.memreq_type = 1'b0;
    bus.way_hit     = 4'b0100;
    bus.memresp_rdy = 1'b1;
    bus.plru_rd     = 3'b000;
    #1;
    checks++;
    if ({bus.memresp_val, bus.sel_way, bus.plru_wen, bus.plru_wd, bus.darray_wen}
        !== {1'b1, 2'd2, 1'b1, 3'b001, 1'b0}) begin
      $display("[TB] FAIL read_hit: got %b want 11010010",
               {bus.memresp_val, bus.sel_way, bus.plru_wen, bus.plru_wd, bus.darray_wen});
      errors++;
    end
    step();
    clearInputs();
    #1;
    checks++;
    if (dut.r_state !== IDLE || bus.memresp_val !== 1'b0) begin
      $display("[TB] FAIL read_hit_idle: state %0d resp %b want 0 0", dut.r_state, bus.memresp_val);
      errors++;
    end
  endtask

  task automatic test_write_hit();
    bus.memreq_val  = 1'b1;
    bus.memreq_type = 1'b1;
    bus.way_hit     = 4'b0010;
    bus.memresp_rdy = 1'b1;
    bus.plru_rd     = 3'b111;
    #1;
    checks++;
    if ({bus.memresp_val, bus.sel_way, bus.darray_wen, bus.dirty_wen, bus.dirty_wd, bus.plru_wd}
        !== {1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 3'b110}) begin
      $display("[TB] FAIL write_hit: got %b want 10111110",
               {bus.memresp_val, bus.sel_way, bus.darray_wen, bus.dirty_wen, bus.dirty_wd, bus.plru_wd});
      errors++;
    end
    step();
    clearInputs();
  endtask

  task automatic test_hit_stall();
    bus.memreq_val  = 1'b1;
    bus.way_hit     = 4'b1000;
    bus.memresp_rdy = 1'b0;
    #1;
    checks++;
    if ({bus.memresp_val, bus.sel_way, bus.plru_wen, bus.plru_wd} !== {1'b1, 2'd3, 1'b1, 3'b000}) begin
      $display("[TB] FAIL stall_hit: got %b want 1111000",
               {bus.memresp_val, bus.sel_way, bus.plru_wen, bus.plru_wd});
      errors++;
    end
    step();
    clearInputs();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({bus.memresp_val, bus.memreq_rdy, bus.plru_wen, bus.sel_way} !== {1'b1, 1'b0, 1'b0, 2'd3}) begin
        $display("[TB] FAIL stall_give%0d: got %b want 10011", c,
                 {bus.memresp_val, bus.memreq_rdy, bus.plru_wen, bus.sel_way});
        errors++;
      end
      step();
    end
    bus.memresp_rdy = 1'b1;
    #1;
    checks++;
    if (bus.memresp_val !== 1'b1 || dut.r_state !== GIVE) begin
      $display("[TB] FAIL stall_accept: resp %b state %0d want 1 5", bus.memresp_val, dut.r_state);
      errors++;
    end
    step();
    bus.memresp_rdy = 1'b0;
    #1;
    checks++;
    if ({bus.memresp_val, bus.memreq_rdy} !== 2'b01) begin
      $display("[TB] FAIL stall_release: got %b want 01", {bus.memresp_val, bus.memreq_rdy});
      errors++;
    end
  endtask

  task automatic test_clean_miss();
    bus.memreq_val  = 1'b1;
    bus.memreq_type = 1'b0;
    bus.plru_rd     = 3'b000;
    bus.memresp_rdy = 1'b1;
    bus.mreq_rdy    = 1'b1;
    #1;
    checks++;
    if ({bus.memreq_rdy, bus.memresp_val, bus.sel_way} !== {1'b1, 1'b0, 2'd0}) begin
      $display("[TB] FAIL clean_miss_idle: got %b want 1000",
               {bus.memreq_rdy, bus.memresp_val, bus.sel_way});
      errors++;
    end
    step();
    bus.memreq_val = 1'b0;
    #1;
    checks++;
    if (dut.r_state !== REFILL || {bus.mreq_val, bus.mreq_rw} !== 2'b10) begin
      $display("[TB] FAIL clean_miss_refill: state %0d req %b want 2 10", dut.r_state,
               {bus.mreq_val, bus.mreq_rw});
      errors++;
    end
    step();
    #1;
    checks++;
    if (dut.r_state !== WAIT_MEM || bus.mresp_rdy !== 1'b1 || bus.tarray_wen !== 4'b0000) begin
      $display("[TB] FAIL clean_miss_wait: state %0d rdy %b twen %b want 3 1 0000", dut.r_state,
               bus.mresp_rdy, bus.tarray_wen);
      errors++;
    end
    bus.mresp_val = 1'b1;
    #1;
    checks++;
    if ({bus.darray_wen, bus.darray_refill_sel, bus.tarray_wen, bus.valid_wen, bus.plru_wen, bus.plru_wd}
        !== {1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1, 3'b011}) begin
      $display("[TB] FAIL clean_miss_fill: got %b want 11000100011011",
               {bus.darray_wen, bus.darray_refill_sel, bus.tarray_wen, bus.valid_wen,
                bus.plru_wen, bus.plru_wd});
      errors++;
    end
    step();
    bus.mresp_val = 1'b0;
    #1;
    checks++;
    if (dut.r_state !== WRITE || {bus.darray_wen, bus.dirty_wen} !== 2'b00) begin
      $display("[TB] FAIL clean_miss_write: state %0d wen %b want 4 00", dut.r_state,
               {bus.darray_wen, bus.dirty_wen});
      errors++;
    end
    step();
    #1;
    checks++;
    if (dut.r_state !== GIVE || bus.memresp_val !== 1'b1) begin
      $display("[TB] FAIL clean_miss_give: state %0d resp %b want 5 1", dut.r_state, bus.memresp_val);
      errors++;
    end
    step();
    clearInputs();
  endtask

  task automatic test_dirty_write_miss();
    bus.memreq_val   = 1'b1;
    bus.memreq_type  = 1'b1;
    bus.plru_rd      = 3'b011;
    bus.victim_dirty = 1'b1;
    bus.memresp_rdy  = 1'b1;
    bus.mreq_rdy     = 1'b0;
    #1;
    checks++;
    if (bus.sel_way !== 2'd1) begin
      $display("[TB] FAIL dirty_miss_victim: got %0d want 1", bus.sel_way);
      errors++;
    end
    step();
    bus.memreq_val   = 1'b0;
    bus.victim_dirty = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (dut.r_state !== WRITEBACK ||
          {bus.mreq_val, bus.mreq_rw, bus.sel_way, bus.dirty_wen, bus.dirty_wd} !== 6'b110110) begin
        $display("[TB] FAIL dirty_miss_wb%0d: state %0d got %b want 1 110110", c, dut.r_state,
                 {bus.mreq_val, bus.mreq_rw, bus.sel_way, bus.dirty_wen, bus.dirty_wd});
        errors++;
      end
      step();
    end
    bus.mreq_rdy = 1'b1;
    step();
    #1;
    checks++;
    if (dut.r_state !== REFILL || {bus.mreq_val, bus.mreq_rw} !== 2'b10) begin
      $display("[TB] FAIL dirty_miss_refill: state %0d req %b want 2 10", dut.r_state,
               {bus.mreq_val, bus.mreq_rw});
      errors++;
    end
    step();
    bus.mresp_val = 1'b1;
    #1;
    checks++;
    if ({bus.tarray_wen, bus.valid_wen, bus.plru_wd} !== {4'b0010, 4'b0010, 3'b110}) begin
      $display("[TB] FAIL dirty_miss_fill: got %b want 00100010110",
               {bus.tarray_wen, bus.valid_wen, bus.plru_wd});
      errors++;
    end
    step();
    bus.mresp_val = 1'b0;
    #1;
    checks++;
    if ({bus.darray_wen, bus.darray_refill_sel, bus.dirty_wen, bus.dirty_wd} !== 4'b1011) begin
      $display("[TB] FAIL dirty_miss_write: got %b want 1011",
               {bus.darray_wen, bus.darray_refill_sel, bus.dirty_wen, bus.dirty_wd});
      errors++;
    end
    step();
    step();
    #1;
    checks++;
    if (dut.r_state !== IDLE || dut.r_pendWrite !== 1'b0) begin
      $display("[TB] FAIL dirty_miss_done: state %0d pend %b want 0 0", dut.r_state, dut.r_pendWrite);
      errors++;
    end
    clearInputs();
  endtask

  task automatic test_reset_wait_mem();
    bus.memreq_val  = 1'b1;
    bus.memreq_type = 1'b1;
    bus.mreq_rdy    = 1'b1;
    step();
    bus.memreq_val = 1'b0;
    step();
    #1;
    checks++;
    if (dut.r_state !== WAIT_MEM || dut.r_pendWrite !== 1'b1) begin
      $display("[TB] FAIL rst_mid_setup: state %0d pend %b want 3 1", dut.r_state, dut.r_pendWrite);
      errors++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.mreq_val, bus.mresp_rdy, bus.memreq_rdy} !== 3'b000) begin
      $display("[TB] FAIL rst_mid_outputs: got %b want 000", {bus.mreq_val, bus.mresp_rdy, bus.memreq_rdy});
      errors++;
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (dut.r_state !== IDLE || dut.r_pendWrite !== 1'b0 || {bus.mreq_val, bus.memreq_rdy} !== 2'b01) begin
      $display("[TB] FAIL rst_mid_idle: state %0d pend %b req/rdy %b want 0 0 01", dut.r_state,
               dut.r_pendWrite, {bus.mreq_val, bus.memreq_rdy});
      errors++;
    end
    clearInputs();
  endtask

`ifdef CACHE_NWAY_CTRL_FLUSH_EN
  task automatic test_flush();
    int   expIdx;
    int   wbCount;
    int   bad;
    logic stall;
    logic dirty;
    logic advance;
    logic finished;
    bus.flush      = 1'b1;
    bus.memreq_val = 1'b1;
    bus.way_hit    = 4'b0001;
    #1;
    checks++;
    if ({bus.memreq_rdy, bus.memresp_val} !== 2'b00) begin
      $display("[TB] FAIL flush_priority: got %b want 00", {bus.memreq_rdy, bus.memresp_val});
      errors++;
    end
    step();
    clearInputs();
    expIdx   = 0;
    wbCount  = 0;
    bad      = 0;
    stall    = 1'b1;
    finished = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      dirty            = (expIdx == 5) || (expIdx == 40);
      bus.victim_dirty = dirty;
      bus.mreq_rdy     = !(expIdx == 40 && stall);
      advance          = !dirty || bus.mreq_rdy;
      #1;
      if (bus.flush_idx !== 6'(expIdx) || bus.flush_active !== 1'b1) bad++;
      if (bus.flush_done !== (advance && expIdx == 63)) bad++;
      if (!dirty && bus.mreq_val !== 1'b0) bad++;
      if (dirty && ({bus.mreq_val, bus.mreq_rw} !== 2'b11 || bus.sel_way !== 2'(expIdx / 16))) bad++;
      if (dirty && bus.mreq_val && bus.mreq_rw && bus.mreq_rdy) wbCount++;
      if (expIdx == 40) stall = 1'b0;
      step();
      if (advance) begin
        if (expIdx == 63) finished = 1'b1;
        else expIdx++;
      end
    end
    clearInputs();
    checks++;
    if (!finished || bad != 0) begin
      $display("[TB] FAIL flush_walk: finished %b bad cycles %0d want 1 0", finished, bad);
      errors++;
    end
    checks++;
    if (wbCount != 2) begin
      $display("[TB] FAIL flush_writebacks: got %0d want 2", wbCount);
      errors++;
    end
    #1;
    checks++;
    if (dut.r_state !== IDLE || bus.flush_idx !== 6'd0 || {bus.flush_active, bus.memreq_rdy} !== 2'b01) begin
      $display("[TB] FAIL flush_end: state %0d idx %0d act/rdy %b want 0 0 01", dut.r_state,
               bus.flush_idx, {bus.flush_active, bus.memreq_rdy});
      errors++;
    end
  endtask
`else
  task automatic test_flush();
    bus.flush       = 1'b1;
    bus.memreq_val  = 1'b1;
    bus.way_hit     = 4'b0001;
    bus.memresp_rdy = 1'b1;
    #1;
    checks++;
    if ({bus.memreq_rdy, bus.memresp_val, bus.flush_active, bus.flush_done, bus.flush_idx}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 6'd0}) begin
      $display("[TB] FAIL flush_ignored: got %b want 1100000000",
               {bus.memreq_rdy, bus.memresp_val, bus.flush_active, bus.flush_done, bus.flush_idx});
      errors++;
    end
    step();
    clearInputs();
    #1;
    checks++;
    if (dut.r_state !== IDLE || bus.flush_active !== 1'b0) begin
      $display("[TB] FAIL flush_ignored_idle: state %0d act %b want 0 0", dut.r_state, bus.flush_active);
      errors++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clearInputs();
    step();
    test_reset();
    test_read_hit();
    test_write_hit();
    test_hit_stall();
    test_clean_miss();
    test_dirty_write_miss();
    test_reset_wait_mem();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
